// File: rtl/fetch_buffer.sv
// fetch_buffer: instruction prefetch queue between fetch and the fetch/decode
// pipeline register. Each entry holds {instr, pc, pc+4}. The read side is
// first-word-fall-through: the head is shown combinationally, and all-zero
// fields are shown when the queue is empty. A redirect (flush) empties the queue.
// Optional macro FETCH_BUF_BYPASS_EN: on an empty queue the incoming entry is
// passed straight to the outputs in the same cycle. It is stored only if
// decode does not take it in that cycle.
module fetch_buffer #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH-1:0]         instr_in,
    input  logic [WIDTH-1:0]         pc_in,
    input  logic [WIDTH-1:0]         pcplus4_in,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         instr_out,
    output logic [WIDTH-1:0]         pc_out,
    output logic [WIDTH-1:0]         pcplus4_out,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [PW-1:0]    rdPtrReg, rdPtrNext;
    logic [PW-1:0]    wrPtrReg, wrPtrNext;
    logic [CW-1:0]    countReg, countNext;

    logic [WIDTH-1:0] instrMem   [DEPTH];
    logic [WIDTH-1:0] pcMem      [DEPTH];
    logic [WIDTH-1:0] pcPlus4Mem [DEPTH];

    logic             isEmpty;
    logic             isFull;
    logic             bypassShow;     // input entry is shown on the outputs this cycle
    logic             bypassConsume;  // decode takes the shown input entry, so it is not stored
    logic             doPush;
    logic             doPop;
    logic [DEPTH-1:0] wrEn;

    assign isEmpty = (countReg == '0);
    assign isFull  = (countReg == CW'(DEPTH));

    // While rst is held low the buffer does not accept entries.
    assign in_ready = rst && !isFull && !flush;

`ifdef FETCH_BUF_BYPASS_EN
    assign bypassShow    = rst && isEmpty && in_valid && !flush;
    assign bypassConsume = bypassShow && out_ready;
`else
    assign bypassShow    = 1'b0;
    assign bypassConsume = 1'b0;
`endif

    // When the entry goes straight through to decode, it never touches storage.
    assign doPush = in_valid && in_ready && !bypassConsume;
    // Flush wins over pop. An empty queue ignores out_ready.
    assign doPop  = !isEmpty && out_ready && !flush;

    // Per-entry write enables decoded from the write pointer.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : gWrEn
        assign wrEn[gi] = doPush && (wrPtrReg == PW'(gi));
    end

    // Next-state for the pointers and occupancy. Flush returns everything to the origin.
    always_comb begin
        rdPtrNext = rdPtrReg;
        wrPtrNext = wrPtrReg;
        countNext = countReg;
        if (flush) begin
            rdPtrNext = '0;
            wrPtrNext = '0;
            countNext = '0;
        end else begin
            if (doPush) wrPtrNext = wrPtrReg + PW'(1);
            if (doPop)  rdPtrNext = rdPtrReg + PW'(1);
            case ({doPush, doPop})
                2'b10:   countNext = countReg + CW'(1);
                2'b01:   countNext = countReg - CW'(1);
                default: countNext = countReg;
            endcase
        end
    end

    // Pointer and occupancy registers. Asserting reset drops all queued entries at once.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rdPtrReg <= '0;
            wrPtrReg <= '0;
            countReg <= '0;
        end else begin
            rdPtrReg <= rdPtrNext;
            wrPtrReg <= wrPtrNext;
            countReg <= countNext;
        end
    end

    // Entry storage. Reset does not clear it because count gates visibility.
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (wrEn[i]) begin
                instrMem[i]   <= instr_in;
                pcMem[i]      <= pc_in;
                pcPlus4Mem[i] <= pcplus4_in;
            end
        end
    end

    // Head presentation: bypassed input, stored head, or an all-zero bubble.
    always_comb begin
        out_valid   = 1'b0;
        instr_out   = '0;
        pc_out      = '0;
        pcplus4_out = '0;
        if (bypassShow) begin
            out_valid   = 1'b1;
            instr_out   = instr_in;
            pc_out      = pc_in;
            pcplus4_out = pcplus4_in;
        end else if (!isEmpty) begin
            out_valid   = 1'b1;
            instr_out   = instrMem[rdPtrReg];
            pc_out      = pcMem[rdPtrReg];
            pcplus4_out = pcPlus4Mem[rdPtrReg];
        end
    end

    assign count = countReg;

endmodule

// File: tb/tb_fetch_buffer.sv
// tb_fetch_buffer: directed and randomized checks of fetch_buffer against a
// queue-based reference model of the prefetch queue.
module tb_fetch_buffer;

    localparam int WIDTH = 32;
    localparam int DEPTH = 4;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] pcp4;
    } entry_t;

    logic                   clk;
    logic                   rst;
    logic                   flush;
    logic                   in_valid;
    logic                   in_ready;
    logic [WIDTH-1:0]       instr_in;
    logic [WIDTH-1:0]       pc_in;
    logic [WIDTH-1:0]       pcplus4_in;
    logic                   out_valid;
    logic                   out_ready;
    logic [WIDTH-1:0]       instr_out;
    logic [WIDTH-1:0]       pc_out;
    logic [WIDTH-1:0]       pcplus4_out;
    logic [$clog2(DEPTH):0] count;

    int     nCompared   = 0;
    int     nMismatched = 0;
    int     stepNo      = 0;
    entry_t q[$];

    fetch_buffer #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .instr_in    (instr_in),
        .pc_in       (pc_in),
        .pcplus4_in  (pcplus4_in),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .instr_out   (instr_out),
        .pc_out      (pc_out),
        .pcplus4_out (pcplus4_out),
        .count       (count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nCompared++;
        assert (obs === exp) else begin
            nMismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock of stimulus: drive, check against the model, clock, update the model.
    task automatic step(input logic iv, input logic [31:0] ins, input logic [31:0] p,
                        input logic ordy, input logic fl);
        logic        expValid;
        logic        expReady;
        logic [31:0] eI, eP, eP4;
        bit          byp;
        bit          doPop, doPush;
        entry_t      e;
        in_valid   = iv;
        instr_in   = ins;
        pc_in      = p;
        pcplus4_in = p + 32'd4;
        out_ready  = ordy;
        flush      = fl;
        #2;
        expReady = (q.size() != DEPTH) && !fl;
        byp = 1'b0;
`ifdef FETCH_BUF_BYPASS_EN
        byp = (q.size() == 0) && iv && !fl;
`endif
        if (byp) begin
            expValid = 1'b1; eI = ins; eP = p; eP4 = p + 32'd4;
        end else if (q.size() != 0) begin
            expValid = 1'b1; eI = q[0].instr; eP = q[0].pc; eP4 = q[0].pcp4;
        end else begin
            expValid = 1'b0; eI = '0; eP = '0; eP4 = '0;
        end
        chk("count",       32'(count),     32'(q.size()));
        chk("out_valid",   32'(out_valid), 32'(expValid));
        chk("in_ready",    32'(in_ready),  32'(expReady));
        chk("instr_out",   instr_out,      eI);
        chk("pc_out",      pc_out,         eP);
        chk("pcplus4_out", pcplus4_out,    eP4);
        $display("step %0d: iv=%0b pc_in=%h ordy=%0b flush=%0b | ov=%0b pc_out=%h count=%0d",
                 stepNo, iv, p, ordy, fl, out_valid, pc_out, count);
        stepNo++;
        @(posedge clk);
        #1;
        if (fl) begin
            q.delete();
        end else begin
            doPop  = (q.size() != 0) && ordy;
            doPush = iv && expReady && !(byp && ordy);
            if (doPop) void'(q.pop_front());
            if (doPush) begin
                e.instr = ins; e.pc = p; e.pcp4 = p + 32'd4;
                q.push_back(e);
            end
        end
    endtask

    initial begin
        logic [31:0] pcCnt;
        rst = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        instr_in = '0; pc_in = '0; pcplus4_in = '0;
        #2;
        chk("reset_count",     32'(count),     32'd0);
        chk("reset_out_valid", 32'(out_valid), 32'd0);
        chk("reset_instr_out", instr_out,      32'd0);
        chk("reset_pc_out",    pc_out,         32'd0);
        #6 rst = 1'b1;
        #1;
        chk("release_in_ready", 32'(in_ready), 32'd1);

        // Push 0x0, 0x4, 0x8 with decode stalled.
        for (int i = 0; i < 3; i++) step(1'b1, $urandom, 32'(i * 4), 1'b0, 1'b0);
        chk("three_count", 32'(count), 32'd3);
        chk("three_pc",    pc_out,     32'h0);
        chk("three_pcp4",  pcplus4_out, 32'h4);

        // Fill to DEPTH, then offer 0x10 while full.
        step(1'b1, $urandom, 32'hC, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b1, $urandom, 32'h10, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

        // Streaming with decode always ready: 16 entries, pointers wrap repeatedly.
        for (int i = 0; i < 16; i++) step(1'b1, $urandom, 32'(i * 4), 1'b1, 1'b0);
        step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

        // Flush with three queued, plus a simultaneous push of 0x40 and a pop.
        for (int i = 0; i < 3; i++) step(1'b1, $urandom, 32'h80 + 32'(i * 4), 1'b0, 1'b0);
        step(1'b1, $urandom, 32'h40, 1'b1, 1'b1);
        step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);

        // Asynchronous reset in the middle of a cycle with two entries queued.
        step(1'b1, $urandom, 32'h300, 1'b0, 1'b0);
        step(1'b1, $urandom, 32'h304, 1'b0, 1'b0);
        in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
        #2;
        chk("pre_rst_count", 32'(count), 32'd2);
        rst = 1'b0;
        #1;
        chk("async_rst_count",     32'(count),     32'd0);
        chk("async_rst_out_valid", 32'(out_valid), 32'd0);
        chk("async_rst_instr_out", instr_out,      32'd0);
        chk("async_rst_pc_out",    pc_out,         32'd0);
        chk("async_rst_pcp4_out",  pcplus4_out,    32'd0);
        q.delete();
        @(posedge clk);
        #1 rst = 1'b1;
        step(1'b1, $urandom, 32'h100, 1'b0, 1'b0);
        chk("post_rst_pc", pc_out, 32'h100);
        step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

        // Empty queue, push with decode ready (zero latency when bypass is built in).
        step(1'b1, 32'h00500093, 32'h200, 1'b1, 1'b0);
        step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        // Empty queue, push with decode stalled.
        step(1'b1, 32'h00a00113, 32'h204, 1'b0, 1'b0);
        step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

        // Randomized traffic.
        pcCnt = 32'h1000;
        for (int i = 0; i < 300; i++) begin
            logic iv, ordy, fl;
            iv   = 1'($urandom_range(0, 1));
            ordy = 1'($urandom_range(0, 2) != 0 ? $urandom_range(0, 1) : 0);
            fl   = ($urandom_range(0, 15) == 0);
            step(iv, $urandom, pcCnt, ordy, fl);
            if (iv) pcCnt = pcCnt + 32'd4;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
